// File: rtl/fp_pkg.sv
// Shared single-precision constants and FSM encoding for the integer/float datapath.
`default_nettype none

package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int BIAS   = 127;

  localparam int SIGN_POS = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_MSB = 22;
  localparam int MANT_LSB = 0;

  localparam int STATE_W = 5;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 5'b00001,
    ST_ABS   = 5'b00010,
    ST_NORM  = 5'b00100,
    ST_ROUND = 5'b01000,
    ST_DONE  = 5'b10000
  } state_t;

  // Exponent of a 32-bit magnitude whose MSB sits at bit 31.
  localparam logic [EXP_W-1:0] EXP_INIT = 8'(BIAS + 31);

endpackage

`default_nettype wire

// File: rtl/fp_rne_round.sv
// Round-to-nearest-even on a normalised 24-bit significand and pack the IEEE-754 single.
`default_nettype none

module fp_rne_round
  import fp_pkg::*;
(
  input  logic              i_sign,
  input  logic [EXP_W-1:0]  i_exp,
  input  logic [MANT_W:0]   i_sig,
  input  logic              i_guard,
  input  logic              i_sticky,
  output logic [31:0]       o_result
);

  logic              w_inc;
  logic [MANT_W:0]   w_sum;
  logic [EXP_W-1:0]  w_exp;
  logic [MANT_W-1:0] w_mant;
  logic              w_unused_hidden;

  assign w_unused_hidden = i_sig[MANT_W];

  // On mantissa carry-out the low bits wrap to zero, which is the required mantissa.
  always_comb begin
    w_inc    = i_guard & (i_sticky | i_sig[0]);
    w_sum    = {1'b0, i_sig[MANT_W-1:0]} + {{MANT_W{1'b0}}, w_inc};
    w_mant   = w_sum[MANT_W-1:0];
    w_exp    = i_exp + {{(EXP_W-1){1'b0}}, w_sum[MANT_W]};
    o_result = {i_sign, w_exp, w_mant};
  end

endmodule

`default_nettype wire

// File: rtl/int_to_fp.sv
// Multi-cycle 32-bit integer to IEEE-754 single converter with iterative normalisation.
`default_nettype none

module int_to_fp
  import fp_pkg::*;
#(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  output logic [31:0] result,
  output logic        done
);

  state_t             r_state;
  logic [31:0]        r_a;
  logic [31:0]        r_mag;
  logic [EXP_W-1:0]   r_exp;
  logic               r_sign;

  logic               w_sign_in;
  logic [31:0]        w_abs;
  logic [31:0]        w_rounded;

  // Negating 0x80000000 yields itself, which is the correct unsigned magnitude.
  assign w_sign_in = SIGNED ? r_a[31] : 1'b0;
  assign w_abs     = w_sign_in ? (~r_a + 32'd1) : r_a;

  fp_rne_round u_round (
    .i_sign   (r_sign),
    .i_exp    (r_exp),
    .i_sig    (r_mag[31:8]),
    .i_guard  (r_mag[7]),
    .i_sticky (|r_mag[6:0]),
    .o_result (w_rounded)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_a     <= 32'd0;
      r_mag   <= 32'd0;
      r_exp   <= '0;
      r_sign  <= 1'b0;
      result  <= 32'd0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_state <= ST_ABS;
          end
        end
        ST_ABS: begin
          r_sign <= w_sign_in;
          r_mag  <= w_abs;
          r_exp  <= EXP_INIT;
          if (w_abs == 32'd0) begin
            result  <= 32'd0;
            done    <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_NORM;
          end
        end
        ST_NORM: begin
          if (r_mag[31]) begin
            r_state <= ST_ROUND;
          end else begin
            r_mag <= r_mag << 1;
            r_exp <= r_exp - 8'd1;
          end
        end
        ST_ROUND: begin
          result  <= w_rounded;
          done    <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_int_to_fp.sv
// Directed-vector bench for int_to_fp: signed and unsigned instances share clock, reset and operand.
`default_nettype none

module tb_int_to_fp;

  logic        clk;
  logic        reset;
  logic        start_s;
  logic        start_u;
  logic [31:0] a;
  logic [31:0] result_s;
  logic [31:0] result_u;
  logic        done_s;
  logic        done_u;

  int errors = 0;
  int checks = 0;

  int_to_fp #(.SIGNED(1'b1)) dut_s (
    .clk    (clk),
    .reset  (reset),
    .start  (start_s),
    .a      (a),
    .result (result_s),
    .done   (done_s)
  );

  int_to_fp #(.SIGNED(1'b0)) dut_u (
    .clk    (clk),
    .reset  (reset),
    .start  (start_u),
    .a      (a),
    .result (result_u),
    .done   (done_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge after the accepting edge (edge 1).
  task automatic launch(input bit sel, input logic [31:0] val);
    a = val;
    if (sel) start_u = 1'b1; else start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    start_u = 1'b0;
  endtask

  task automatic wait_done(input bit sel, output int lat, output logic [31:0] res);
    lat = 1;
    while (!(sel ? done_u : done_s) && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    res = sel ? result_u : result_s;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_s = 1'b0; start_u = 1'b0; a = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    checks++; if (result_s !== 32'd0) begin errors++; $display("FAIL reset_result_s got %h want 00000000", result_s); end
    checks++; if (result_u !== 32'd0) begin errors++; $display("FAIL reset_result_u got %h want 00000000", result_u); end
    checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL reset_done_s got %b want 0", done_s); end
    checks++; if (done_u !== 1'b0) begin errors++; $display("FAIL reset_done_u got %b want 0", done_u); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_signed();
    logic [31:0] va[5] = '{32'h00000001, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32'h00000003};
    logic [31:0] vr[5] = '{32'h3F800000, 32'hBF800000, 32'hCF000000, 32'h00000000, 32'h40400000};
    int          vl[5] = '{35, 35, 4, 2, 34};
    int          lat;
    logic [31:0] res;
    for (int i = 0; i < 5; i++) begin
      launch(1'b0, va[i]);
      wait_done(1'b0, lat, res);
      checks++; if (res !== vr[i]) begin errors++; $display("FAIL signed_result[%0d] a=%h got %h want %h", i, va[i], res, vr[i]); end
      checks++; if (lat !== vl[i]) begin errors++; $display("FAIL signed_latency[%0d] a=%h got %0d want %0d", i, va[i], lat, vl[i]); end
      @(negedge clk);
      checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL signed_done_width[%0d] got %b want 0", i, done_s); end
    end
  endtask

  task automatic test_rounding();
    logic [31:0] va[3] = '{32'h01000001, 32'h01000003, 32'h7FFFFFFF};
    logic [31:0] vr[3] = '{32'h4B800000, 32'h4B800002, 32'h4F000000};
    int          vl[3] = '{11, 11, 5};
    int          lat;
    logic [31:0] res;
    for (int i = 0; i < 3; i++) begin
      launch(1'b0, va[i]);
      wait_done(1'b0, lat, res);
      checks++; if (res !== vr[i]) begin errors++; $display("FAIL round_result[%0d] a=%h got %h want %h", i, va[i], res, vr[i]); end
      checks++; if (lat !== vl[i]) begin errors++; $display("FAIL round_latency[%0d] a=%h got %0d want %0d", i, va[i], lat, vl[i]); end
      @(negedge clk);
      checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL round_done_width[%0d] got %b want 0", i, done_s); end
    end
  endtask

  task automatic test_unsigned();
    logic [31:0] va[3] = '{32'hFFFFFFFF, 32'h80000000, 32'h00000001};
    logic [31:0] vr[3] = '{32'h4F800000, 32'h4F000000, 32'h3F800000};
    int          vl[3] = '{4, 4, 35};
    int          lat;
    logic [31:0] res;
    for (int i = 0; i < 3; i++) begin
      launch(1'b1, va[i]);
      wait_done(1'b1, lat, res);
      checks++; if (res !== vr[i]) begin errors++; $display("FAIL unsigned_result[%0d] a=%h got %h want %h", i, va[i], res, vr[i]); end
      checks++; if (lat !== vl[i]) begin errors++; $display("FAIL unsigned_latency[%0d] a=%h got %0d want %0d", i, va[i], lat, vl[i]); end
      @(negedge clk);
      checks++; if (done_u !== 1'b0) begin errors++; $display("FAIL unsigned_done_width[%0d] got %b want 0", i, done_u); end
    end
  endtask

  task automatic test_start_ignored();
    int          lat;
    logic [31:0] res;
    launch(1'b0, 32'h00000001);
    repeat (4) @(negedge clk);
    a = 32'h80000000;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    lat = 6;
    while (!done_s && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    res = result_s;
    checks++; if (res !== 32'h3F800000) begin errors++; $display("FAIL ignored_start_result got %h want 3F800000", res); end
    checks++; if (lat !== 35) begin errors++; $display("FAIL ignored_start_latency got %0d want 35", lat); end
    repeat (3) @(negedge clk);
    checks++; if (result_s !== 32'h3F800000) begin errors++; $display("FAIL result_hold got %h want 3F800000", result_s); end
    checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL no_second_done got %b want 0", done_s); end
  endtask

  task automatic test_reset_mid();
    int          lat;
    int          pulses;
    logic [31:0] res;
    launch(1'b0, 32'h00000001);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_s) pulses++;
      @(negedge clk);
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL reset_mid_done got %0d pulses want 0", pulses); end
    checks++; if (result_s !== 32'd0) begin errors++; $display("FAIL reset_mid_result got %h want 00000000", result_s); end
    launch(1'b0, 32'h00000003);
    wait_done(1'b0, lat, res);
    checks++; if (res !== 32'h40400000) begin errors++; $display("FAIL after_reset_result got %h want 40400000", res); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL after_reset_latency got %0d want 34", lat); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int          lat;
    logic [31:0] res;
    launch(1'b0, 32'h80000000);
    wait_done(1'b0, lat, res);
    checks++; if (res !== 32'hCF000000) begin errors++; $display("FAIL b2b_first_result got %h want CF000000", res); end
    // Start held across the DONE cycle: only the IDLE-cycle operand may be taken.
    a = 32'h80000000;
    start_s = 1'b1;
    @(negedge clk);
    a = 32'h00000001;
    @(negedge clk);
    start_s = 1'b0;
    wait_done(1'b0, lat, res);
    checks++; if (res !== 32'h3F800000) begin errors++; $display("FAIL b2b_second_result got %h want 3F800000", res); end
    checks++; if (lat !== 35) begin errors++; $display("FAIL b2b_second_latency got %0d want 35", lat); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_signed();
    test_rounding();
    test_unsigned();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/int_to_fp.md
Name: int_to_fp

Overview:
- Multi-cycle converter from a 32-bit integer to an IEEE-754 single-precision float. The result uses round-to-nearest-even.
- It produces operands for the floating-point add/sub datapath and uses the same start/done handshake.
- Normalisation is iterative, one bit per cycle, to keep area small. Latency therefore depends on the operand.

Parameters:
- SIGNED, 1, 1: treat a as two's complement. 0: treat a as unsigned.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a conversion; sampled only in IDLE
- a  input  32  integer operand; captured on the edge where start is accepted
- result  output  32  IEEE-754 single; registered; valid when done=1, held until the next conversion completes
- done  output  1  one-cycle pulse; result is valid in that cycle

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high on port reset.
- Reset values: state=IDLE, result=0x00000000, done=0, internal mag/exp/sign=0.
- Reset mid-operation: asserting reset in any state aborts the conversion. No done pulse is produced. State is IDLE on the next cycle.
- States: IDLE, ABS, NORM, ROUND, DONE (encoding comes from the package).
- IDLE:
  - done=0.
  - If start=1: capture a and go to ABS.
  - start in any other state is ignored; the operand is not queued.
- ABS:
  - sign = SIGNED ? a[31] : 0.
  - mag (32-bit unsigned) = sign ? (~a+1) : a. For a=0x80000000, mag=0x80000000 (no overflow).
  - exp = 158 (127+31).
  - If mag==0: result=0x00000000 (+0 always), go to DONE.
  - Otherwise go to NORM.
- NORM:
  - If mag[31]=1: go to ROUND.
  - Otherwise: mag<=mag<<1, exp<=exp-1, stay in NORM.
  - Takes lz+1 cycles, where lz = leading zeros of mag (0..31).
- ROUND:
  - mant = mag[30:8], guard = mag[7], sticky = |mag[6:0].
  - inc = guard & (sticky | mant[0]).
  - {carry,mant'} = mant + inc. If carry=1: mant'=0 and exp+1.
  - result <= {sign, exp[7:0], mant'}. Go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. A start during DONE is ignored.
- Latency: counting the start-sampling edge as edge 1, done is high after edge lz+4 for nonzero operands and after edge 2 for zero. Maximum is 35 edges (a=1).
- Exponent range: exp stays within 127..159. No overflow, denormal, NaN or Inf outputs are possible.
- Back-to-back: the earliest next accepted start is in the IDLE cycle right after DONE.

Decomposition:
- Package fp_pkg (shared with the add/sub datapath):
  - EXP_W=8, MANT_W=23, BIAS=127.
  - FSM state localparams, 5-bit state register width.
  - Field-slice helper constants for sign, exponent and mantissa positions.
- One natural combinational sub-module, fp_rne_round: inputs sign, exp, 24-bit normalised significand and guard/sticky; output the packed 32-bit float. The add/sub ROUND state reuses it.
- Leading-zero handling stays iterative inside int_to_fp. There is no separate LZC module.

Test Plan:
- a=0x00000001, SIGNED=1 -> result=0x3F800000; done pulses after edge 35; done high for exactly 1 cycle.
- a=0xFFFFFFFF (-1), SIGNED=1 -> 0xBF800000. a=0x80000000 -> 0xCF000000 (lz=0, done after edge 4).
- a=0 -> 0x00000000 with done after edge 2. A start pulse asserted during NORM of a prior conversion is ignored; the prior result is unaffected.
- Rounding:
  - a=0x01000001 -> 0x4B800000 (tie, round to even, down).
  - a=0x01000003 -> 0x4B800002 (tie, odd lsb, round up).
  - a=0x7FFFFFFF -> 0x4F000000 (mantissa carry, exponent increments).
- SIGNED=0: a=0xFFFFFFFF -> 0x4F800000. a=0x80000000 -> 0x4F000000.
- Reset asserted for one cycle mid-NORM (a=1, after edge 10) -> no done pulse, result=0x00000000, state IDLE. A new start with a=3 then gives 0x40400000.
